input_debouncer: RTL
====================

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on in (legal values 2 to 4).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive sampled cycles a new level must persist before it is accepted (legal values 1 to 65535).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in, input, 1 bit: raw asynchronous level, such as a button or external pin.
REQ-006 SHALL have port out, output, 1 bit: debounced, clk-synchronous level that feeds the edge_detector in input.
REQ-007 SHALL have port busy, output, 1 bit: high while a candidate level change is being qualified.
REQ-008 SHALL have port glitch_cnt, output, 8 bits: count of rejected transitions, saturating.

Function
REQ-009 SHALL pass in through a SYNC_STAGES-deep flop chain; the last flop, sync_q, is the only internal use of in.
REQ-010 SHALL implement a two-state FSM with states STABLE and CHECK, plus a counter cnt of width clog2(DEBOUNCE_CYCLES+1).
REQ-011 STABLE: when sync_q equals out, SHALL hold with cnt=0; when sync_q differs from out, SHALL move to CHECK with cnt=1.
REQ-011a STABLE, DEBOUNCE_CYCLES=1 exception: when sync_q differs from out, out SHALL take sync_q on that same edge and the FSM SHALL stay in STABLE.
REQ-012 CHECK: when sync_q differs from out and cnt is below DEBOUNCE_CYCLES, cnt SHALL increment.
REQ-013 CHECK: when cnt reaches DEBOUNCE_CYCLES with sync_q still differing, out SHALL take sync_q on that edge; cnt SHALL clear and the FSM SHALL return to STABLE.
REQ-014 CHECK: when sync_q equals out before acceptance, the FSM SHALL return to STABLE with cnt=0, out unchanged, and glitch_cnt incremented.
REQ-015 busy SHALL be high exactly when the state is CHECK.
REQ-016 Latency: a level change on in that is held SHALL appear on out at the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge after the change; the default is 6 edges.
REQ-017 out SHALL change at most once per qualification, and SHALL never change while sync_q equals out.
REQ-018 glitch_cnt SHALL saturate at 255 and SHALL never wrap.
REQ-019 Simultaneous events: rst SHALL take priority over acceptance and over glitch counting on the same edge.

Reset
REQ-020 When rst=1 at a rising edge, all sync flops, out, cnt and glitch_cnt SHALL be set to 0, and the state SHALL be set to STABLE.
REQ-021 busy SHALL be 0 on the edge after reset is sampled.
REQ-022 A reset asserted mid-CHECK SHALL discard the qualification in progress; after release, a held input SHALL again need the full REQ-016 latency.
REQ-023 An X or unknown on in during reset SHALL NOT propagate to out.

Configuration
REQ-024 Macro INPUT_DEBOUNCER_STATS_EN: when defined, the glitch_cnt logic per REQ-014 and REQ-018 SHALL be compiled in.
REQ-025 When INPUT_DEBOUNCER_STATS_EN is not defined, the glitch_cnt port SHALL remain present and be tied to 8'd0, and no counter flops SHALL be synthesized.

Structure
REQ-026 Package input_debouncer_pkg SHALL hold the FSM state encoding (STABLE=1'b0, CHECK=1'b1) and the GLITCH_CNT_W=8 constant.
REQ-027 The synchronizer chain SHALL be a separate sub-module, bit_synchronizer, parameterized by its number of stages, and reusable by other input stages.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, macro defined)
REQ-028 Reset: rst=1 for 2 edges with in=1 -> out=0, busy=0, glitch_cnt=0 throughout.
REQ-029 Clean rise: in goes 0->1 between edges and is held 10 cycles -> out rises on the 6th edge; busy is high for 4 cycles; glitch_cnt stays 0.
REQ-030 Glitch: in=1 for 2 cycles then back to 0 -> out stays 0, busy pulses, glitch_cnt=1.
REQ-031 Clean fall: from out=1, in goes 1->0 and is held -> out falls on the 6th edge; the edge_detector downstream emits exactly one nedge pulse.
REQ-032 Reset mid-CHECK: rst=1 for 1 edge while busy=1 and in=1 held -> out=0, busy=0; after release, out rises 6 edges later.
REQ-033 Saturation: apply 300 glitches -> glitch_cnt=255; rebuild without the macro and repeat -> glitch_cnt=0 and out behaviour is identical.

Source files
------------

// File: rtl/input_debouncer_pkg.sv
// input_debouncer_pkg: FSM state encoding and shared constants for the input debouncer.
`default_nettype none

package input_debouncer_pkg;

  localparam int GLITCH_CNT_W = 8;

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: STAGES-deep flop chain that brings an asynchronous bit into the clk domain.
`default_nettype none

module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/input_debouncer.sv
// input_debouncer: synchronizes and debounces a raw level; optional glitch statistics
// compiled in with INPUT_DEBOUNCER_STATS_EN (otherwise glitch_cnt is tied to zero).
`default_nettype none

module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in,
  output logic                    out,
  output logic                    busy,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The edge that would bring cnt up to DEBOUNCE_CYCLES is the accepting edge.
  localparam logic [CNT_W-1:0] ACCEPT_AT = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync_q;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (in),
    .q   (sync_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STABLE;
      cnt   <= '0;
      out   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        STABLE: begin
          if (sync_q != out) begin
            if (DEBOUNCE_CYCLES == 1) begin
              out <= sync_q;
              cnt <= '0;
            end else begin
              state <= CHECK;
              cnt   <= CNT_W'(1);
              busy  <= 1'b1;
            end
          end else begin
            cnt <= '0;
          end
        end
        CHECK: begin
          if (sync_q == out) begin
            state <= STABLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt >= ACCEPT_AT) begin
            out   <= sync_q;
            state <= STABLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef INPUT_DEBOUNCER_STATS_EN
  logic glitch_evt;

  // A candidate that reverts before acceptance counts as one rejected transition.
  assign glitch_evt = (state == CHECK) && (sync_q == out);

  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_cnt <= '0;
    end else if (glitch_evt && (glitch_cnt != {GLITCH_CNT_W{1'b1}})) begin
      glitch_cnt <= glitch_cnt + 1'b1;
    end
  end
`else
  assign glitch_cnt = '0;
`endif

endmodule

`default_nettype wire
